// File: rtl/riscv_mem_pkg.sv
// Shared types for the riscv_core memory-port arbitration logic.
package riscv_mem_pkg;

   localparam int unsigned DEFAULT_XLEN = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_IF = 2'd1,
      WAIT_LS = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive LS grants taken while IF was waiting.
module arb_streak_counter #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nx;

   // clr wins over inc; the count holds once it reaches MAX
   always_comb begin
      cnt_nx = cnt;
      if (clr) begin
         cnt_nx = '0;
      end else if (inc && (cnt != W'(MAX))) begin
         cnt_nx = cnt + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sat <= 1'b0;
      end else begin
         cnt <= cnt_nx;
         sat <= (cnt_nx == W'(MAX));
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch and load/store,
// one outstanding transaction at a time, LS-priority with an IF anti-starvation limit.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned XLEN          = DEFAULT_XLEN,
   parameter int unsigned MAX_LS_STREAK = 4,
   parameter int unsigned TIMEOUT       = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [XLEN-1:0]   ls_addr,
   input  logic [XLEN-1:0]   ls_wdata,
   input  logic [XLEN/8-1:0] ls_be,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [XLEN-1:0]   ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_be,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   arb_state_t    state;
   arb_state_t    state_nx;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_cnt_nx;
   logic          wr_q;
   logic          wr_nx;
   owner_t        owner;
   logic          streak_sat;
   logic          streak_inc;
   logic          streak_clr;
   logic          wait_expired;

   arb_streak_counter #(
      .MAX (MAX_LS_STREAK)
   ) u_streak (
      .clk   (clk),
      .rst_n (reset),
      .inc   (streak_inc),
      .clr   (streak_clr),
      .sat   (streak_sat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         wr_q     <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         wr_q     <= wr_nx;
      end
   end

   // Arbitration, payload mux and response demux; port outputs follow mem_* directly
   always_comb begin
      if_gnt      = 1'b0;
      if_rvalid   = 1'b0;
      if_rdata    = '0;
      ls_gnt      = 1'b0;
      ls_rvalid   = 1'b0;
      ls_rdata    = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      err         = 1'b0;
      busy        = (state != IDLE);
      streak_inc  = 1'b0;
      streak_clr  = 1'b0;
      state_nx    = state;
      wait_cnt_nx = '0;
      wr_nx       = wr_q;
      owner        = (ls_req && !(if_req && streak_sat)) ? OWN_LS : OWN_IF;
      wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

      unique case (state)
         IDLE: begin
            mem_req = ls_req | if_req;
            // a response with nothing outstanding is reported and dropped
            err     = mem_rvalid;
            if (owner == OWN_LS) begin
               mem_we    = ls_we;
               mem_addr  = ls_addr;
               mem_wdata = ls_wdata;
               mem_be    = ls_be;
               ls_gnt    = mem_gnt;
            end else begin
               mem_addr  = if_addr;
               mem_be    = '1;
               if_gnt    = mem_gnt & if_req;
            end
            streak_inc = ls_gnt & if_req;
            streak_clr = if_gnt | (ls_gnt & ~if_req);
            if (ls_gnt) begin
               state_nx = WAIT_LS;
               wr_nx    = ls_we;
            end else if (if_gnt) begin
               state_nx = WAIT_IF;
               wr_nx    = 1'b0;
            end
         end

         WAIT_IF: begin
            wait_cnt_nx = wait_cnt + CW'(1);
            if (mem_rvalid) begin
               if_rvalid   = 1'b1;
               if_rdata    = mem_rdata;
               state_nx    = IDLE;
               wait_cnt_nx = '0;
            end else if (wait_expired) begin
               if_rvalid   = 1'b1;
               err         = 1'b1;
               state_nx    = IDLE;
               wait_cnt_nx = '0;
            end
         end

         WAIT_LS: begin
            wait_cnt_nx = wait_cnt + CW'(1);
            if (mem_rvalid) begin
               ls_rvalid   = 1'b1;
               ls_rdata    = wr_q ? '0 : mem_rdata;
               state_nx    = IDLE;
               wait_cnt_nx = '0;
            end else if (wait_expired) begin
               ls_rvalid   = 1'b1;
               err         = 1'b1;
               state_nx    = IDLE;
               wait_cnt_nx = '0;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      // reset silences the port immediately, even with requests still high
      if (!reset) begin
         if_gnt     = 1'b0;
         if_rvalid  = 1'b0;
         if_rdata   = '0;
         ls_gnt     = 1'b0;
         ls_rvalid  = 1'b0;
         ls_rdata   = '0;
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         mem_addr   = '0;
         mem_wdata  = '0;
         mem_be     = '0;
         err        = 1'b0;
         busy       = 1'b0;
         streak_inc = 1'b0;
         streak_clr = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs checked 1 ns later.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_be;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_mis = 0;

   // expected grant owner per starvation transaction, bit i: 1 = LS, 0 = IF
   logic [9:0] ls_order = 10'b0111101111;

   mem_port_arbiter #(
      .XLEN          (32),
      .MAX_LS_STREAK (4),
      .TIMEOUT       (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .ls_req     (ls_req),
      .ls_we      (ls_we),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_be      (ls_be),
      .ls_gnt     (ls_gnt),
      .ls_rvalid  (ls_rvalid),
      .ls_rdata   (ls_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // reset with requests already high: everything must stay quiet
      reset = 1'b0; if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0;
      ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
      mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      nxt(); settle();
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_if_gnt", if_gnt, 1'b0);
      chk1("rst_ls_gnt", ls_gnt, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      nxt(); reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; mem_gnt = 1'b0;

      // 1. IF-only read
      nxt(); if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1; settle();
      chk1("t1_if_gnt", if_gnt, 1'b1);
      chk1("t1_mem_req", mem_req, 1'b1);
      chk32("t1_mem_addr", mem_addr, 32'h100);
      chk32("t1_mem_be", {28'd0, mem_be}, 32'hF);
      chk1("t1_mem_we", mem_we, 1'b0);
      nxt(); if_req = 1'b0; mem_gnt = 1'b0; settle();
      chk1("t1_busy", busy, 1'b1);
      chk1("t1_wait_mem_req", mem_req, 1'b0);
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; settle();
      chk1("t1_if_rvalid", if_rvalid, 1'b1);
      chk32("t1_if_rdata", if_rdata, 32'h0050_0093);
      chk1("t1_ls_rvalid", ls_rvalid, 1'b0);
      chk1("t1_err", err, 1'b0);
      nxt(); mem_rvalid = 1'b0; settle();
      chk1("t1_idle_busy", busy, 1'b0);
      chk1("t1_if_rvalid_low", if_rvalid, 1'b0);

      // 2. contention: LS write beats IF, IF follows after the LS response
      nxt(); if_req = 1'b1; if_addr = 32'h104;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF;
      mem_gnt = 1'b1; settle();
      chk1("t2_ls_gnt", ls_gnt, 1'b1);
      chk1("t2_if_gnt", if_gnt, 1'b0);
      chk1("t2_mem_we", mem_we, 1'b1);
      chk32("t2_mem_be", {28'd0, mem_be}, 32'hF);
      chk32("t2_mem_addr", mem_addr, 32'h200);
      chk32("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      nxt(); ls_req = 1'b0; mem_gnt = 1'b0; settle();
      chk1("t2_wait_if_gnt", if_gnt, 1'b0);
      chk1("t2_wait_mem_req", mem_req, 1'b0);
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; settle();
      chk1("t2_ls_rvalid", ls_rvalid, 1'b1);
      chk32("t2_ls_rdata_wr", ls_rdata, 32'h0);
      chk1("t2_if_rvalid", if_rvalid, 1'b0);
      nxt(); mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
      chk1("t2_if_gnt_after", if_gnt, 1'b1);
      chk32("t2_if_addr", mem_addr, 32'h104);
      chk1("t2_if_we", mem_we, 1'b0);
      nxt(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011; settle();
      chk1("t2_if_rvalid", if_rvalid, 1'b1);
      chk32("t2_if_rdata", if_rdata, 32'h0000_0011);

      // 3. starvation guard: LS and IF both held, LS read
      if_req = 1'b1; if_addr = 32'h108;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; ls_be = 4'h3;
      for (int i = 0; i < 10; i++) begin
         nxt(); mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
         chk1("t3_ls_gnt", ls_gnt, ls_order[i]);
         chk1("t3_if_gnt", if_gnt, !ls_order[i]);
         nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i); settle();
         chk1("t3_ls_rvalid", ls_rvalid, ls_order[i]);
         chk1("t3_if_rvalid", if_rvalid, !ls_order[i]);
         chk32("t3_rdata", ls_order[i] ? ls_rdata : if_rdata, 32'hA000_0000 + 32'(i));
      end
      nxt(); mem_rvalid = 1'b0; if_req = 1'b0; ls_req = 1'b0;

      // 4. timeout on an LS read (TIMEOUT = 8)
      nxt(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; mem_gnt = 1'b1; settle();
      chk1("t4_ls_gnt", ls_gnt, 1'b1);
      nxt(); ls_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hAAAA_5555;
      for (int k = 1; k < 8; k++) begin
         settle();
         chk1("t4_no_err", err, 1'b0);
         chk1("t4_no_rvalid", ls_rvalid, 1'b0);
         chk1("t4_busy", busy, 1'b1);
         nxt();
      end
      settle();
      chk1("t4_err", err, 1'b1);
      chk1("t4_ls_rvalid", ls_rvalid, 1'b1);
      chk32("t4_ls_rdata", ls_rdata, 32'h0);
      chk1("t4_if_rvalid", if_rvalid, 1'b0);
      nxt(); settle();
      chk1("t4_idle_busy", busy, 1'b0);
      chk1("t4_err_low", err, 1'b0);

      // 5. reset while an IF read is outstanding
      nxt(); if_req = 1'b1; if_addr = 32'h500; mem_gnt = 1'b1; settle();
      chk1("t5_if_gnt", if_gnt, 1'b1);
      nxt(); if_req = 1'b0; mem_gnt = 1'b0; settle();
      chk1("t5_busy", busy, 1'b1);
      nxt(); reset = 1'b0; if_req = 1'b1; mem_gnt = 1'b1; settle();
      chk1("t5_rst_busy", busy, 1'b0);
      chk1("t5_rst_mem_req", mem_req, 1'b0);
      chk1("t5_rst_if_gnt", if_gnt, 1'b0);
      chk32("t5_rst_mem_addr", mem_addr, 32'h0);
      nxt(); reset = 1'b1; if_req = 1'b0; mem_gnt = 1'b0;
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; settle();
      chk1("t5_late_err", err, 1'b1);
      chk1("t5_late_if_rvalid", if_rvalid, 1'b0);
      chk1("t5_late_busy", busy, 1'b0);
      nxt(); mem_rvalid = 1'b0;

      // 6. stray response while idle
      nxt(); mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD; settle();
      chk1("t6_err", err, 1'b1);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_if_rvalid", if_rvalid, 1'b0);
      chk1("t6_ls_rvalid", ls_rvalid, 1'b0);
      nxt(); mem_rvalid = 1'b0; settle();
      chk1("t6_err_low", err, 1'b0);
      chk1("t6_busy_low", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
